// File: rtl/loader_pkg.sv
// Shared widths, state encoding and word/byte types for the byte-to-word loader.
package loader_pkg;
  localparam int WORD_W_DEF = 32;
  localparam int BYTE_W_DEF = 8;
  localparam int NBYTES     = WORD_W_DEF / BYTE_W_DEF;
  localparam int CNT_W      = $clog2(NBYTES);

  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

  typedef logic [WORD_W_DEF-1:0] word_t;
  typedef logic [BYTE_W_DEF-1:0] byte_t;
endpackage

// File: rtl/byte_lane_shifter.sv
// Combinational lane writer: picks the byte lane to fill and builds the next word,
// starting from a cleared word when the held word is leaving.
module byte_lane_shifter
  import loader_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int BYTE_W = BYTE_W_DEF,
  parameter int NL     = NBYTES,
  parameter int CW     = CNT_W
) (
  input  logic [WORD_W-1:0] word_i,
  input  logic [CW-1:0]     cnt_i,
  input  logic [BYTE_W-1:0] data_i,
  input  logic              wr_i,
  input  logic              clr_i,
  output logic [NL-1:0]     lane_we_o,
  output logic [WORD_W-1:0] word_o
);
  logic [CW-1:0] sel;

  always_comb begin
    // A cleared word always restarts at lane 0.
    sel       = clr_i ? '0 : cnt_i;
    lane_we_o = '0;
    word_o    = clr_i ? '0 : word_i;
    for (int i = 0; i < NL; i++) begin
      if (wr_i && (sel == CW'(i))) begin
        lane_we_o[i]                  = 1'b1;
        word_o[i*BYTE_W +: BYTE_W]    = data_i;
      end
    end
  end
endmodule

// File: rtl/byte_word_loader.sv
// Packs a little-endian byte stream into words on a valid/ready output, flagging
// the frame's last word and zero-padding a partial one.
module byte_word_loader
  import loader_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int BYTE_W = BYTE_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_last,
  output logic              out_short
);
  localparam int NL = WORD_W / BYTE_W;
  localparam int CW = (NL > 1) ? $clog2(NL) : 1;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WORD_W-1:0] word_q, word_d, shift_word;
  logic              last_q, last_d;
  logic              short_q, short_d;
  logic [NL-1:0]     lane_we;
  logic              in_xfer, out_xfer;

  assign out_valid = (state_q == HOLD);
  // While holding, a byte may only enter when the held word leaves in the same cycle.
  assign in_ready  = (state_q == FILL) || out_ready;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;
  assign out_data  = word_q;
  assign out_last  = last_q;
  assign out_short = short_q;

  byte_lane_shifter #(
    .WORD_W (WORD_W),
    .BYTE_W (BYTE_W),
    .NL     (NL),
    .CW     (CW)
  ) u_shifter (
    .word_i    (word_q),
    .cnt_i     (cnt_q),
    .data_i    (in_data),
    .wr_i      (in_xfer),
    .clr_i     (out_xfer),
    .lane_we_o (lane_we),
    .word_o    (shift_word)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    last_d  = last_q;
    short_d = short_q;
    case (state_q)
      FILL: begin
        if (in_xfer) begin
          word_d = shift_word;
          if (lane_we[NL-1] || in_last) begin
            state_d = HOLD;
            cnt_d   = '0;
            last_d  = in_last;
            short_d = in_last && !lane_we[NL-1];
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      HOLD: begin
        if (out_xfer) begin
          word_d  = shift_word;
          state_d = FILL;
          cnt_d   = '0;
          last_d  = 1'b0;
          short_d = 1'b0;
          if (in_xfer) begin
            if (lane_we[NL-1] || in_last) begin
              state_d = HOLD;
              last_d  = in_last;
              short_d = in_last && !lane_we[NL-1];
            end else begin
              cnt_d = CW'(1);
            end
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      cnt_q   <= '0;
      word_q  <= '0;
      last_q  <= 1'b0;
      short_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      last_q  <= last_d;
      short_q <= short_d;
    end
  end
endmodule

// File: tb/tb_byte_word_loader.sv
// Directed bench for byte_word_loader: a word-level reference model checked every
// cycle, plus literal expectations for each delivered word.
module tb_byte_word_loader;
  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        out_short;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model state: completed words awaiting delivery, and the word being built.
  logic [33:0] mq[$];
  logic [33:0] got[$];
  logic [31:0] macc = '0;
  int          mn   = 0;

  byte_word_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_short (out_short)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic ev, ox, ix, ms;
    if (!rst_n) begin
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data",  64'(out_data),  64'd0);
      chk("rst_out_flags", 64'({out_last, out_short}), 64'd0);
      mq.delete();
      macc = '0;
      mn   = 0;
    end else begin
      ev = (mq.size() != 0);
      chk("out_valid", 64'(out_valid), 64'(ev));
      if (ev) chk("out_word", 64'({out_last, out_short, out_data}), 64'(mq[0]));
      chk("in_ready", 64'(in_ready), 64'(!ev || out_ready));
      ox = ev && out_ready;
      ix = in_valid && (!ev || out_ready);
      if (out_valid && out_ready) got.push_back({out_last, out_short, out_data});
      if (ox) void'(mq.pop_front());
      if (ix) begin
        macc[mn*8 +: 8] = in_data;
        mn++;
        if (mn == 4 || in_last) begin
          ms = (mn < 4);
          mq.push_back({in_last, ms, macc});
          macc = '0;
          mn   = 0;
        end
      end
    end
  end

  task automatic send(input logic [7:0] b, input logic l);
    int   n;
    logic acc;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    in_last  = l;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 50);
    chk("send_accept", 64'(acc), 64'd1);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    in_last  = 1'($urandom);
  endtask

  logic [33:0] exp_words [10];
  int t0;

  initial begin
    exp_words = '{
      {2'b00, 32'h04030201}, {2'b11, 32'h0000BBAA}, {2'b00, 32'h44434241},
      {2'b00, 32'h14131211}, {2'b00, 32'h13121110}, {2'b00, 32'h17161514},
      {2'b00, 32'h34333231}, {2'b00, 32'h54535251}, {2'b11, 32'h0000007F},
      {2'b10, 32'h64636261}};
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_in_ready",  64'(in_ready),  64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_data",  64'(out_data),  64'd0);
    @(posedge clk); #1;

    // Full word, visible the cycle after the 4th byte.
    for (int i = 1; i <= 4; i++) send(8'(i), 1'b0);
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_word",  64'({out_last, out_short, out_data}), {30'd0, 2'b00, 32'h04030201});

    // Short final word.
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b1);
    chk("t2_word", 64'({out_last, out_short, out_data}), {30'd0, 2'b11, 32'h0000BBAA});

    // Back-pressure for 5 cycles, then release together with a new byte.
    send(8'h41, 1'b0); send(8'h42, 1'b0); send(8'h43, 1'b0);
    out_ready = 1'b0;
    send(8'h44, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_data",     64'(out_data), 64'h44434241);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(8'h11, 1'b0);
    chk("t3_lane0", 64'(out_valid), 64'd0);
    send(8'h12, 1'b0); send(8'h13, 1'b0); send(8'h14, 1'b0);

    // Streaming: 8 bytes must take exactly 8 cycles.
    t0 = cyc;
    for (int i = 0; i < 8; i++) send(8'h10 + 8'(i), 1'b0);
    chk("stream_cycles", 64'(cyc - t0), 64'd8);

    // Reset in the middle of a word.
    send(8'h21, 1'b0); send(8'h22, 1'b0); send(8'h23, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) send(8'h30 + 8'(i), 1'b0);
    chk("t5_word", 64'(out_data), 64'h34333231);

    // Single-byte final word accepted during an output transfer.
    send(8'h51, 1'b0); send(8'h52, 1'b0); send(8'h53, 1'b0);
    out_ready = 1'b0;
    send(8'h54, 1'b0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(8'h7F, 1'b1);
    chk("t6_word", 64'({out_last, out_short, out_data}), {30'd0, 2'b11, 32'h0000007F});

    // Frame ending exactly on a full word.
    send(8'h61, 1'b0); send(8'h62, 1'b0); send(8'h63, 1'b0); send(8'h64, 1'b1);
    chk("t7_word", 64'({out_last, out_short, out_data}), {30'd0, 2'b10, 32'h64636261});

    repeat (3) @(posedge clk);
    #1;
    chk("word_count", 64'(got.size()), 64'd10);
    for (int i = 0; i < 10; i++) begin
      if (i < got.size()) chk($sformatf("word_%0d", i), 64'(got[i]), 64'(exp_words[i]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end
endmodule
